i2c_init_sequencer: RTL and testbench
=====================================

Name: i2c_init_sequencer

Overview:
- Upstream command source for the I2C write master: walks a table of register writes, e.g. a codec/sensor power-up configuration, and issues them one at a time over the master's start/ready handshake.
- Each write uses a fixed device address.
- Supports inline delay entries and an end-of-table marker.
- Reports busy/done/error to the system controller.

Parameters:
- NUM_CMDS, 32: table depth in entries; address width is clog2(NUM_CMDS).
- DEV_ID, 8'h34: byte driven on mst_dev_id for every write.
- DELAY_CYCLES, 1000: clk cycles per delay unit.
- ACCEPT_TIMEOUT, 16: maximum cycles after the start pulse for mst_ready to fall.
- DONE_TIMEOUT, 1024: maximum cycles for mst_ready to return high.

Ports:
- clk, in, 1: system clock; the master runs on the same clk.
- reset, in, 1: synchronous, active-high.
- go, in, 1: starts the sequence; sampled only in IDLE, DONE or ERROR.
- tbl_addr, out, clog2(NUM_CMDS): table read address.
- tbl_entry, in, 16: synchronous-ROM data, valid 1 cycle after tbl_addr; [15:8] is reg, [7:0] is data.
- mst_ready, in, 1: master idle indication.
- mst_start, out, 1: single-cycle start pulse to the master.
- mst_dev_id, out, 8: constant DEV_ID.
- mst_reg_id, out, 8: register address for the current write.
- mst_data, out, 8: data byte for the current write.
- busy, out, 1: high in every state except IDLE, DONE and ERROR.
- done, out, 1: sticky; sequence completed.
- error, out, 1: sticky; a handshake timeout occurred.
- cmd_index, out, clog2(NUM_CMDS)+1: current or last entry index.
- dbg_state, out, 4: current FSM state encoding.

Behaviour:
- All outputs are registered.
- Reset values: mst_start=0, mst_reg_id=0, mst_data=0, tbl_addr=0, busy=0, done=0, error=0, cmd_index=0, state=IDLE, counters=0.
- Reset is honoured in any state, including mid-delay and mid-handshake. mst_start is 0 from the first clk edge with reset high.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACCEPT, WAIT_DONE, DELAY, DONE, ERROR.
- IDLE / DONE / ERROR: on go=1, set cmd_index=0, clear done and error, go to FETCH. go is ignored in all other states.
- FETCH: tbl_addr <= cmd_index; go to DECODE. tbl_entry is consumed on the following cycle.
- DECODE, by tbl_entry[15:8]:
  - 8'hFE (END): go to DONE, done <= 1.
  - 8'hFF (DELAY): if data == 0, advance the index; else load the unit counter with data and the cycle counter with DELAY_CYCLES-1, then go to DELAY.
  - Otherwise: mst_reg_id <= [15:8], mst_data <= [7:0], go to ISSUE.
- ISSUE: wait for mst_ready=1. On that cycle set mst_start <= 1, clear the timeout counter, go to WAIT_ACCEPT. mst_start is high for exactly one cycle.
- WAIT_ACCEPT:
  - mst_start <= 0.
  - On mst_ready=0, go to WAIT_DONE.
  - If the counter reaches ACCEPT_TIMEOUT first, go to ERROR with error <= 1.
- WAIT_DONE:
  - On mst_ready=1, advance the index.
  - If the counter reaches DONE_TIMEOUT first, go to ERROR.
- mst_reg_id / mst_data hold stable from DECODE until the next DECODE of a write entry.
- DELAY:
  - The cycle counter counts down; at 0 it reloads and the unit counter decrements.
  - When the unit counter reaches 0, advance the index.
  - Total delay is data × DELAY_CYCLES cycles, ±1.
- Advance index:
  - cmd_index <= cmd_index+1.
  - If the new index == NUM_CMDS (table exhausted without END), go to DONE with done <= 1; else go to FETCH.
- The per-entry overhead of FETCH+DECODE is 2 cycles before ISSUE.
- ERROR: cmd_index freezes at the failing entry.
- Simultaneous go and reset: reset wins.
- mst_ready already low at ISSUE (master not idle): stall in ISSUE indefinitely; no timeout. The master is reset-released asynchronously by the system.

Decomposition:
- Package i2c_pkg, shared with the master:
  - state encodings for this FSM;
  - CMD_END=8'hFE and CMD_DELAY=8'hFF;
  - default DEV_ID;
  - entry field positions REG_MSB/LSB and DATA_MSB/LSB.
- Sub-module i2c_init_rom is natural as the table source:
  - synchronous read, 1-cycle latency, contents from an init file;
  - instantiated beside the sequencer at top level, not inside it.
- The delay and timeout counters stay inline.

Test Plan:
1. Table {0x0102, 0x0203, 0xFE00}; master model holds ready low for 30 cycles after each start -> two start pulses of 1 cycle each with (0x34,0x01,0x02) then (0x34,0x02,0x03); done=1, cmd_index=2, error=0.
2. Table {0xFF03, 0x1055, 0xFE00}, DELAY_CYCLES=10 -> start for 0x10/0x55 occurs 30±1 cycles after the DELAY entry is decoded; entry 0xFF00 adds no delay.
3. Master ready stuck high after start -> error=1 exactly ACCEPT_TIMEOUT=16 cycles after the start pulse; busy=0, cmd_index=0, no further starts.
4. Full 32-entry table with no END -> 32 writes issued; done=1 with cmd_index=32.
5. Reset asserted in WAIT_DONE of entry 1 -> next cycle all outputs at reset values; go after release restarts at entry 0.
6. go pulsed while busy -> ignored, sequence unchanged; go in DONE -> done cleared, sequence reruns from entry 0.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Definitions shared by the I2C init sequencer and the write
//                master: sequencer state encodings, special table opcodes,
//                the default device address and the table entry field layout.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_FETCH       = 4'd1,
    ST_DECODE      = 4'd2,
    ST_ISSUE       = 4'd3,
    ST_WAIT_ACCEPT = 4'd4,
    ST_WAIT_DONE   = 4'd5,
    ST_DELAY       = 4'd6,
    ST_DONE        = 4'd7,
    ST_ERROR       = 4'd8
  } seq_state_t;

  localparam logic [7:0] CMD_END        = 8'hFE;
  localparam logic [7:0] CMD_DELAY      = 8'hFF;
  localparam logic [7:0] DEFAULT_DEV_ID = 8'h34;

  // Table entry layout: {register, data}
  localparam int REG_MSB  = 15;
  localparam int REG_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/i2c_init_rom.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_init_rom
//  Description : Synchronous-read command table for the init sequencer.
//                One cycle read latency; contents are supplied as a packed
//                image (entry i at bits [16*i +: 16]).
//  Ports       : clk       - system clock
//                tbl_addr  - read address
//                tbl_entry - registered read data, valid 1 cycle after addr
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_init_rom #(
  parameter int                     NUM_CMDS = 32,
  parameter logic [NUM_CMDS*16-1:0] INIT     = '0
) (
  input  logic                        clk,
  input  logic [$clog2(NUM_CMDS)-1:0] tbl_addr,
  output logic [15:0]                 tbl_entry
);

  logic [15:0] w_mem [NUM_CMDS];

  for (genvar gi = 0; gi < NUM_CMDS; gi++) begin : g_mem
    assign w_mem[gi] = INIT[gi*16 +: 16];
  end

  always_ff @(posedge clk) begin
    tbl_entry <= w_mem[tbl_addr];
  end

endmodule
`default_nettype wire

// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_init_sequencer
//  Description : Walks a table of register writes and issues them one at a
//                time to the I2C write master over a start/ready handshake.
//                Supports inline delay entries and an end-of-table marker.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                go                  - start sequence (IDLE/DONE/ERROR only)
//                tbl_addr, tbl_entry - synchronous table read interface
//                mst_ready/mst_start - master handshake
//                mst_dev_id/reg_id/data - write command fields
//                busy, done, error   - status (done/error sticky)
//                cmd_index, dbg_state - progress / debug
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_init_sequencer
  import i2c_pkg::*;
#(
  parameter int         NUM_CMDS       = 32,
  parameter logic [7:0] DEV_ID         = DEFAULT_DEV_ID,
  parameter int         DELAY_CYCLES   = 1000,
  parameter int         ACCEPT_TIMEOUT = 16,
  parameter int         DONE_TIMEOUT   = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        go,
  output logic [$clog2(NUM_CMDS)-1:0] tbl_addr,
  input  logic [15:0]                 tbl_entry,
  input  logic                        mst_ready,
  output logic                        mst_start,
  output logic [7:0]                  mst_dev_id,
  output logic [7:0]                  mst_reg_id,
  output logic [7:0]                  mst_data,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [$clog2(NUM_CMDS):0]   cmd_index,
  output logic [3:0]                  dbg_state
);

  localparam int AW = $clog2(NUM_CMDS);
  localparam int IW = AW + 1;
  localparam int CW = $clog2(DELAY_CYCLES + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + ACCEPT_TIMEOUT + 1);

  seq_state_t    r_state, w_state_n;
  logic [IW-1:0] r_idx,   w_idx_n;
  logic [AW-1:0] r_addr,  w_addr_n;
  logic [7:0]    r_reg,   w_reg_n;
  logic [7:0]    r_data,  w_data_n;
  logic          r_start, w_start_n;
  logic          r_busy,  w_busy_n;
  logic          r_done,  w_done_n;
  logic          r_err,   w_err_n;
  logic [7:0]    r_unit,  w_unit_n;
  logic [CW-1:0] r_cyc,   w_cyc_n;
  logic [TW-1:0] r_to,    w_to_n;
  logic          w_adv;

  logic [7:0] w_ent_reg, w_ent_data;
  assign w_ent_reg  = tbl_entry[REG_MSB:REG_LSB];
  assign w_ent_data = tbl_entry[DATA_MSB:DATA_LSB];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_addr  <= '0;
      r_reg   <= '0;
      r_data  <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_unit  <= '0;
      r_cyc   <= '0;
      r_to    <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_addr  <= w_addr_n;
      r_reg   <= w_reg_n;
      r_data  <= w_data_n;
      r_start <= w_start_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      r_unit  <= w_unit_n;
      r_cyc   <= w_cyc_n;
      r_to    <= w_to_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_addr_n  = r_addr;
    w_reg_n   = r_reg;
    w_data_n  = r_data;
    w_start_n = 1'b0;
    w_done_n  = r_done;
    w_err_n   = r_err;
    w_unit_n  = r_unit;
    w_cyc_n   = r_cyc;
    w_to_n    = r_to;
    w_adv     = 1'b0;

    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (go) begin
          w_idx_n   = '0;
          w_addr_n  = '0;
          w_done_n  = 1'b0;
          w_err_n   = 1'b0;
          w_state_n = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // The address is already presented whenever the index changes, so
        // the ROM registers it at the end of FETCH and data lands in DECODE.
        w_addr_n  = r_idx[AW-1:0];
        w_state_n = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_ent_reg == CMD_END) begin
          w_state_n = ST_DONE;
          w_done_n  = 1'b1;
        end else if (w_ent_reg == CMD_DELAY) begin
          if (w_ent_data == 8'd0) begin
            w_adv = 1'b1;
          end else begin
            w_unit_n  = w_ent_data;
            w_cyc_n   = CW'(DELAY_CYCLES - 1);
            w_state_n = ST_DELAY;
          end
        end else begin
          w_reg_n   = w_ent_reg;
          w_data_n  = w_ent_data;
          w_state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A master that is not idle stalls us here with no timeout.
        if (mst_ready) begin
          w_start_n = 1'b1;
          w_to_n    = '0;
          w_state_n = ST_WAIT_ACCEPT;
        end
      end
      ST_WAIT_ACCEPT: begin
        if (!mst_ready) begin
          w_to_n    = '0;
          w_state_n = ST_WAIT_DONE;
        end else if (r_to == TW'(ACCEPT_TIMEOUT - 1)) begin
          w_err_n   = 1'b1;
          w_state_n = ST_ERROR;
        end else begin
          w_to_n = r_to + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (mst_ready) begin
          w_adv = 1'b1;
        end else if (r_to == TW'(DONE_TIMEOUT - 1)) begin
          w_err_n   = 1'b1;
          w_state_n = ST_ERROR;
        end else begin
          w_to_n = r_to + TW'(1);
        end
      end
      ST_DELAY: begin
        if (r_cyc == '0) begin
          if (r_unit == 8'd1) begin
            w_adv = 1'b1;
          end else begin
            w_unit_n = r_unit - 8'd1;
            w_cyc_n  = CW'(DELAY_CYCLES - 1);
          end
        end else begin
          w_cyc_n = r_cyc - CW'(1);
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    if (w_adv) begin
      w_idx_n  = r_idx + IW'(1);
      w_addr_n = w_idx_n[AW-1:0];
      if (w_idx_n == IW'(NUM_CMDS)) begin
        w_state_n = ST_DONE;
        w_done_n  = 1'b1;
      end else begin
        w_state_n = ST_FETCH;
      end
    end

    w_busy_n = !((w_state_n == ST_IDLE) || (w_state_n == ST_DONE) ||
                 (w_state_n == ST_ERROR));
  end

  assign tbl_addr   = r_addr;
  assign mst_start  = r_start;
  assign mst_dev_id = DEV_ID;
  assign mst_reg_id = r_reg;
  assign mst_data   = r_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_err;
  assign cmd_index  = r_idx;
  assign dbg_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_init_sequencer
//  Description : Self-checking bench for i2c_init_sequencer with a table ROM
//                model, a simple master model and a write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_init_sequencer;

  localparam int NC = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic [4:0]  tbl_addr;
  logic [15:0] tbl_entry;
  logic        mst_ready;
  logic        mst_start;
  logic [7:0]  mst_dev_id, mst_reg_id, mst_data;
  logic        busy, done, error;
  logic [5:0]  cmd_index;
  logic [3:0]  dbg_state;

  i2c_init_sequencer #(
    .NUM_CMDS(NC), .DEV_ID(8'h34), .DELAY_CYCLES(10),
    .ACCEPT_TIMEOUT(16), .DONE_TIMEOUT(1024)
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .tbl_addr(tbl_addr), .tbl_entry(tbl_entry),
    .mst_ready(mst_ready), .mst_start(mst_start),
    .mst_dev_id(mst_dev_id), .mst_reg_id(mst_reg_id), .mst_data(mst_data),
    .busy(busy), .done(done), .error(error),
    .cmd_index(cmd_index), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Table ROM model: one-cycle synchronous read.
  logic [15:0] tbl [NC];
  always @(posedge clk) tbl_entry <= tbl[tbl_addr];

  // Master model: after a start it drops ready on the next cycle and holds
  // it low for 30 cycles. With stuck set it never reacts.
  logic stuck = 1'b0;
  int   mcnt;
  always @(posedge clk) begin
    if (reset) begin
      mst_ready <= 1'b1;
      mcnt      <= 0;
    end else if (mst_start && !stuck) begin
      mst_ready <= 1'b0;
      mcnt      <= 30;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mst_ready <= 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected {reg,data} per write, popped on each start pulse.
  logic [15:0] exp_q [$];
  int   n_starts = 0;
  int   start_cyc = 0;
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (mst_start) begin
      n_starts++;
      start_cyc = cyc;
      check("start_width", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_start: got reg %0h data %0h expected none",
                 mst_reg_id, mst_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("dev_id", {24'd0, mst_dev_id}, 32'h34);
        check("reg_data", {16'd0, mst_reg_id, mst_data}, {16'd0, e});
      end
    end
    prev_start = mst_start;
  end

  int go_cyc = 0;

  task automatic pulse_go();
    @(negedge clk);
    go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_end(input int bound);
    int k;
    k = 0;
    while (!(!busy && (done || error)) && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (k >= bound) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_end_timeout: got %0d cycles expected < %0d", k, bound);
    end
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < NC; i++) tbl[i] = 16'hFE00;
  endtask

  task automatic load3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    clear_tbl();
    tbl[0] = a; tbl[1] = b; tbl[2] = c;
  endtask

  initial begin
    int err_cyc;
    int s0;
    clear_tbl();
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_start", {31'd0, mst_start}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_index", {26'd0, cmd_index}, 32'd0);
    check("rst_state", {28'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    // 1: two writes then END
    load3(16'h0102, 16'h0203, 16'hFE00);
    exp_q.push_back(16'h0102);
    exp_q.push_back(16'h0203);
    s0 = n_starts;
    pulse_go();
    wait_end(500);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_index", {26'd0, cmd_index}, 32'd2);
    check("t1_starts", n_starts - s0, 32'd2);
    check("t1_q_empty", exp_q.size(), 32'd0);

    // 2: zero-length delay costs only its own FETCH+DECODE:
    // go sampled -> FETCH, DECODE(delay), FETCH, DECODE, ISSUE, start = +6
    load3(16'hFF00, 16'h1055, 16'hFE00);
    exp_q.push_back(16'h1055);
    pulse_go();
    wait_end(500);
    check("t2_delay0_lat", start_cyc - go_cyc, 32'd6);
    // 3 units x 10 cycles adds 30 cycles on top of that path
    load3(16'hFF03, 16'h1055, 16'hFE00);
    exp_q.push_back(16'h1055);
    pulse_go();
    wait_end(500);
    check("t2_delay3_lat", start_cyc - go_cyc, 32'd36);
    check("t2_done", {31'd0, done}, 32'd1);

    // 3: master never accepts -> error 16 cycles after the start pulse
    stuck = 1'b1;
    load3(16'h0102, 16'hFE00, 16'hFE00);
    exp_q.push_back(16'h0102);
    s0 = n_starts;
    pulse_go();
    err_cyc = -1;
    for (int k = 0; k < 200 && err_cyc < 0; k++) begin
      if (error) err_cyc = cyc;
      else @(negedge clk);
    end
    check("t3_err_lat", err_cyc - start_cyc, 32'd16);
    check("t3_error", {31'd0, error}, 32'd1);
    check("t3_busy", {31'd0, busy}, 32'd0);
    check("t3_done", {31'd0, done}, 32'd0);
    check("t3_index", {26'd0, cmd_index}, 32'd0);
    repeat (20) @(negedge clk);
    check("t3_starts", n_starts - s0, 32'd1);
    stuck = 1'b0;

    // 4: full table with no END
    for (int i = 0; i < NC; i++) begin
      tbl[i] = {8'(8'h20 + i), 8'(i * 3)};
      exp_q.push_back({8'(8'h20 + i), 8'(i * 3)});
    end
    s0 = n_starts;
    pulse_go();
    wait_end(3000);
    check("t4_done", {31'd0, done}, 32'd1);
    check("t4_index", {26'd0, cmd_index}, 32'd32);
    check("t4_starts", n_starts - s0, 32'd32);
    check("t4_q_empty", exp_q.size(), 32'd0);

    // 5: reset during WAIT_DONE of entry 1
    load3(16'h0102, 16'h0203, 16'hFE00);
    exp_q.push_back(16'h0102);
    exp_q.push_back(16'h0203);
    s0 = n_starts;
    pulse_go();
    for (int k = 0; k < 300 && (n_starts - s0) < 2; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("t5_in_wait_done", {28'd0, dbg_state}, 32'd5);
    reset = 1'b1;
    @(negedge clk);
    check("t5_start", {31'd0, mst_start}, 32'd0);
    check("t5_reg", {24'd0, mst_reg_id}, 32'd0);
    check("t5_data", {24'd0, mst_data}, 32'd0);
    check("t5_addr", {27'd0, tbl_addr}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_index", {26'd0, cmd_index}, 32'd0);
    check("t5_state", {28'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    exp_q.push_back(16'h0102);
    exp_q.push_back(16'h0203);
    pulse_go();
    wait_end(500);
    check("t5_rerun_done", {31'd0, done}, 32'd1);
    check("t5_rerun_index", {26'd0, cmd_index}, 32'd2);

    // 6: go while busy is ignored; go in DONE reruns
    exp_q.push_back(16'h0102);
    exp_q.push_back(16'h0203);
    s0 = n_starts;
    pulse_go();
    repeat (10) @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_end(500);
    check("t6_starts", n_starts - s0, 32'd2);
    check("t6_index", {26'd0, cmd_index}, 32'd2);
    exp_q.push_back(16'h0102);
    exp_q.push_back(16'h0203);
    pulse_go();
    check("t6_done_cleared", {31'd0, done}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd1);
    wait_end(500);
    check("t6_rerun_done", {31'd0, done}, 32'd1);
    check("t6_q_empty", exp_q.size(), 32'd0);

    // go together with reset: reset wins
    @(negedge clk);
    go = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    go = 1'b0;
    reset = 1'b0;
    check("gr_state", {28'd0, dbg_state}, 32'd0);
    check("gr_busy", {31'd0, busy}, 32'd0);
    check("gr_done", {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    check("gr_stays_idle", {28'd0, dbg_state}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
